mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-port unified memory between the instruction-fetch path and the load/store path.
//  Sits between the PC/instruction-fetch logic and the ALU/data path on one side, and the memory on the other.
//  Arbitrates requests, sequences a fixed-latency memory access, and returns data with a one-cycle ready pulse.
//  Lets a multi-cycle processor variant run from a single memory macro.
// PARAMETERS
//  ADDR_W      32  address width of all address ports
//  DATA_W      32  data width of all data ports
//  MEM_LAT     2   cycles mem_en is held per access; mem_rdata is valid in the last one (legal range 1..15)
//  STARVE_MAX  4   consecutive lost arbitrations before fetch is forced (only with ARB_STARVE_GUARD_EN)
// PORTS
//  clk        in   1       system clock, rising edge
//  reset      in   1       asynchronous, active-high reset
//  if_req     in   1       fetch request; held with if_addr until if_ready
//  if_addr    in   ADDR_W  fetch address
//  if_ready   out  1       one-cycle pulse: fetch complete, if_rdata valid
//  if_rdata   out  DATA_W  fetched instruction, registered
//  d_req      in   1       data request; held with d_we/d_addr/d_wdata until d_ready
//  d_we       in   1       1 = store, 0 = load
//  d_addr     in   ADDR_W  data address
//  d_wdata    in   DATA_W  store data
//  d_ready    out  1       one-cycle pulse: data access complete
//  d_rdata    out  DATA_W  load data, registered
//  mem_en     out  1       memory access enable
//  mem_we     out  1       memory write enable
//  mem_addr   out  ADDR_W  memory address
//  mem_wdata  out  DATA_W  memory write data
//  mem_rdata  in   DATA_W  memory read data
//  busy       out  1       1 whenever state != IDLE
//  owner_d    out  1       1 = data port owns the memory, 0 = fetch port (valid while busy)
// BEHAVIOUR
//  - Reset (async): state=IDLE; every output 0 (including rdata registers); counters 0; any in-flight access aborted with no ready pulse.
//  - FSM states are IDLE, ACCESS and DONE.
//    - IDLE: samples the requests. If d_req, grant data; else if if_req, grant fetch; else stay in IDLE.
//      A grant latches addr/we/wdata and the owner into registers, then moves to ACCESS.
//    - ACCESS: holds for exactly MEM_LAT cycles.
//      mem_en=1; mem_addr/mem_wdata come from the latched registers; mem_we = latched we and owner_d.
//      On the last cycle, a read latches mem_rdata into the owner's rdata register; then moves to DONE.
//    - DONE: the owner's ready=1 for one cycle; mem_en=0; next state is IDLE.
//  - Latency: req seen at IDLE edge t gives ready high in cycle t+MEM_LAT+1. One access per MEM_LAT+2 cycles.
//  - Store: d_rdata is unchanged; mem_we is never asserted for fetch.
//  - Priority: data beats fetch when both are requested in the same IDLE cycle. Fetch is held off; it is not dropped.
//  - A requester dropping req mid-access is a protocol violation. The access completes anyway and ready still pulses.
//  - A new req held during DONE is sampled in the following IDLE cycle as a new transaction.
//  - Non-owner ready is always 0. The two ready signals are never high together.
//  - MEM_LAT counter width is 4 bits; it reloads on every grant, with no wrap within an access.
// CONFIGURATION
//  ARB_STARVE_GUARD_EN defined:
//  - A 4-bit starve counter increments each IDLE grant where d_req && if_req and data wins.
//  - It clears on any fetch grant.
//  - When it reaches STARVE_MAX, the next IDLE with if_req grants fetch even if d_req is high.
//  - The counter saturates at STARVE_MAX and resets to 0.
//  ARB_STARVE_GUARD_EN undefined: strict data priority; counter logic absent.
// TESTING
//  - Reset: assert reset mid-ACCESS -> busy, mem_en, if_ready and d_ready all 0 immediately; no ready after release.
//  - Fetch, MEM_LAT=2: if_req with if_addr=0x10, mem returns 0x00500113 -> mem_en high 2 cycles, mem_addr=0x10, if_ready at cycle 3, if_rdata=0x00500113.
//  - Store: d_req, d_we=1, d_addr=0x40, d_wdata=0xDEADBEEF -> mem_we=1 for 2 cycles with that addr/data; d_ready pulses once; d_rdata unchanged.
//  - Collision: if_req and d_req (load 0x44) in the same cycle -> data served first (owner_d=1); fetch served next, if_ready 4 cycles after d_ready.
//  - Starvation, with ARB_STARVE_GUARD_EN and STARVE_MAX=4: if_req held and d_req continuous -> exactly 4 data grants, then 1 fetch grant; without the macro, fetch is never granted.
//  - Back-to-back fetches 0x0, 0x4, 0x8 -> if_ready spacing is exactly MEM_LAT+2 cycles; rdata values match memory.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store, fixed-latency access.
// Optional macro ARB_STARVE_GUARD_EN: forces a fetch grant after STARVE_MAX consecutive data wins.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner_d
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t     state;
  logic [3:0] lat_cnt;
  logic       force_fetch;
  logic       grant_d;
  logic       grant_f;

`ifdef ARB_STARVE_GUARD_EN
  logic [3:0] starve_cnt;

  assign force_fetch = if_req && (starve_cnt >= 4'(STARVE_MAX));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (state == IDLE) begin
      if (grant_f)
        starve_cnt <= '0;
      else if (grant_d && if_req && (starve_cnt < 4'(STARVE_MAX)))
        starve_cnt <= starve_cnt + 4'd1;
    end
  end
`else
  // Strict data priority; the threshold parameter has no effect in this build.
  assign force_fetch = (STARVE_MAX < 0);
`endif

  always_comb begin
    grant_d = d_req && !force_fetch;
    grant_f = if_req && !grant_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      lat_cnt   <= '0;
      if_ready  <= 1'b0;
      d_ready   <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      owner_d   <= 1'b0;
    end else begin
      if_ready <= 1'b0;
      d_ready  <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_d || grant_f) begin
            // mem_addr/mem_wdata/mem_we double as the latched request registers.
            state     <= ACCESS;
            busy      <= 1'b1;
            mem_en    <= 1'b1;
            owner_d   <= grant_d;
            lat_cnt   <= 4'(MEM_LAT - 1);
            mem_addr  <= grant_d ? d_addr : if_addr;
            mem_wdata <= grant_d ? d_wdata : '0;
            mem_we    <= grant_d && d_we;
          end
        end
        ACCESS: begin
          if (lat_cnt == 4'd0) begin
            state  <= DONE;
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            if (owner_d) begin
              d_ready <= 1'b1;
              if (!mem_we)
                d_rdata <= mem_rdata;
            end else begin
              if_ready <= 1'b1;
              if_rdata <= mem_rdata;
            end
          end else begin
            lat_cnt <= lat_cnt - 4'd1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a transaction-level timing model.
// Compile with ARB_STARVE_GUARD_EN defined to check the starvation guard build.
module tb_mem_port_arbiter;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int MEM_LAT    = 2;
  localparam int STARVE_MAX = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              if_req = 1'b0;
  logic [ADDR_W-1:0] if_addr = '0;
  logic              if_ready;
  logic [DATA_W-1:0] if_rdata;
  logic              d_req = 1'b0;
  logic              d_we = 1'b0;
  logic [ADDR_W-1:0] d_addr = '0;
  logic [DATA_W-1:0] d_wdata = '0;
  logic              d_ready;
  logic [DATA_W-1:0] d_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;
  logic              owner_d;

  logic              mem_init = 1'b0;
  logic [DATA_W-1:0] mem     [64];
  logic [DATA_W-1:0] ref_mem [64];

  int n_tests = 0;
  int n_fail  = 0;

  // Transaction-level model: grant edge, owner, and the derived access window.
  int          n       = 0;
  int          free_at = 0;
  int          g_edge  = -100;
  bit          g_d     = 1'b0;
  bit          g_we    = 1'b0;
  logic [31:0] g_addr  = '0;
  logic [31:0] g_wdata = '0;
  logic [31:0] g_val   = '0;
  int          starve  = 0;
  logic [31:0] e_if_rdata = '0;
  logic [31:0] e_d_rdata  = '0;
  bit          e_if_done  = 1'b0;
  bit          e_d_done   = 1'b0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .MEM_LAT   (MEM_LAT),
    .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_ready (if_ready),
    .if_rdata (if_rdata),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_ready  (d_ready),
    .d_rdata  (d_rdata),
    .mem_en   (mem_en),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .busy     (busy),
    .owner_d  (owner_d)
  );

  function automatic logic [31:0] seed_word(int i);
    return (32'(i) * 32'h9E37_79B1) ^ 32'h0050_0113;
  endfunction

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= seed_word(i);
    end else if (mem_en && mem_we) begin
      mem[mem_addr[7:2]] <= mem_wdata;
    end
  end

  assign mem_rdata = mem_en ? mem[mem_addr[7:2]] : 32'hBAD0_BAD0;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", tag, n, got, exp);
    end
  endtask

  task automatic model_edge();
    bit force_f;
    force_f = 1'b0;
    if (!reset && n >= free_at && (if_req || d_req)) begin
`ifdef ARB_STARVE_GUARD_EN
      force_f = if_req && (starve >= STARVE_MAX);
`endif
      g_d = d_req && !force_f;
      if (g_d) begin
        g_we    = d_we;
        g_addr  = d_addr;
        g_wdata = d_wdata;
        if (if_req) starve = (starve < STARVE_MAX) ? starve + 1 : STARVE_MAX;
        if (g_we) ref_mem[g_addr[7:2]] = g_wdata;
      end else begin
        g_we    = 1'b0;
        g_addr  = if_addr;
        g_wdata = '0;
        starve  = 0;
      end
      g_val   = ref_mem[g_addr[7:2]];
      g_edge  = n;
      free_at = n + MEM_LAT + 2;
    end
  endtask

  task automatic model_check();
    bit in_acc;
    bit done;
    in_acc    = (n >= g_edge) && (n < g_edge + MEM_LAT);
    done      = (n == g_edge + MEM_LAT);
    e_if_done = done && !g_d;
    e_d_done  = done && g_d;
    if (e_if_done) e_if_rdata = g_val;
    if (e_d_done && !g_we) e_d_rdata = g_val;
    check("busy",     64'(busy),     64'(in_acc || done));
    check("mem_en",   64'(mem_en),   64'(in_acc));
    check("mem_we",   64'(mem_we),   64'(in_acc && g_d && g_we));
    check("if_ready", 64'(if_ready), 64'(e_if_done));
    check("d_ready",  64'(d_ready),  64'(e_d_done));
    check("if_rdata", 64'(if_rdata), 64'(e_if_rdata));
    check("d_rdata",  64'(d_rdata),  64'(e_d_rdata));
    if (in_acc) begin
      check("mem_addr", 64'(mem_addr), 64'(g_addr));
      if (g_d && g_we) check("mem_wdata", 64'(mem_wdata), 64'(g_wdata));
    end
    if (in_acc || done) check("owner_d", 64'(owner_d), 64'(g_d));
  endtask

  task automatic drive(int if_rate, int d_rate);
    if (e_if_done) if_req = 1'b0;
    if (e_d_done) d_req = 1'b0;
    if (!if_req && ($urandom_range(0, 99) < if_rate)) begin
      if_req  = 1'b1;
      if_addr = 32'($urandom_range(0, 63)) << 2;
    end
    if (!d_req && ($urandom_range(0, 99) < d_rate)) begin
      d_req   = 1'b1;
      d_we    = 1'($urandom_range(0, 1));
      d_addr  = 32'($urandom_range(0, 63)) << 2;
      d_wdata = $urandom;
    end
  endtask

  task automatic cycle(int if_rate, int d_rate);
    @(posedge clk);
    n++;
    model_edge();
    #1;
    model_check();
    drive(if_rate, d_rate);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) ref_mem[i] = seed_word(i);
    mem_init = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy",     64'(busy),      64'(0));
    check("rst_mem_en",   64'(mem_en),    64'(0));
    check("rst_mem_we",   64'(mem_we),    64'(0));
    check("rst_mem_addr", 64'(mem_addr),  64'(0));
    check("rst_if_ready", 64'(if_ready),  64'(0));
    check("rst_d_ready",  64'(d_ready),   64'(0));
    check("rst_if_rdata", 64'(if_rdata),  64'(0));
    check("rst_d_rdata",  64'(d_rdata),   64'(0));
    check("rst_owner_d",  64'(owner_d),   64'(0));
    mem_init = 1'b0;
    reset    = 1'b0;

    repeat (400) cycle(30, 30);
    repeat (200) cycle(100, 100);
    repeat (100) cycle(100, 0);
    repeat (150) cycle(60, 60);
    repeat (12) cycle(0, 0);

    // Abort a fetch mid-access with an asynchronous reset.
    if_req  = 1'b1;
    if_addr = 32'h10;
    cycle(0, 0);
    check("abort_pre_mem_en", 64'(mem_en), 64'(1));
    #2;
    reset = 1'b1;
    #1;
    check("abort_busy",     64'(busy),     64'(0));
    check("abort_mem_en",   64'(mem_en),   64'(0));
    check("abort_if_ready", 64'(if_ready), 64'(0));
    check("abort_d_ready",  64'(d_ready),  64'(0));
    check("abort_if_rdata", 64'(if_rdata), 64'(0));
    if_req     = 1'b0;
    g_edge     = -100;
    free_at    = 0;
    starve     = 0;
    e_if_rdata = '0;
    e_d_rdata  = '0;
    @(negedge clk);
    reset = 1'b0;
    repeat (MEM_LAT + 4) cycle(0, 0);

    repeat (100) cycle(40, 40);
    repeat (12) cycle(0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
